// File: rtl/mux_cfg_mem_loader.sv
// Mux configuration writer: serialises valid/ready bitstream words LSB-first into a shadow chain and commits it atomically to mem/mem_inv.
// Optional macro CFG_PARITY_EN adds cfg_parity (even parity per word) and a sticky cfg_err that blocks the commit.
module mux_cfg_mem_loader #(
  parameter int NUM_BITS = 16,
  parameter int WORD_W   = 8
) (
  input  logic                prog_clk,
  input  logic                pReset_n,
  input  logic                cfg_start,
  input  logic [WORD_W-1:0]   cfg_word,
  input  logic                cfg_valid,
`ifdef CFG_PARITY_EN
  input  logic                cfg_parity,
`endif
  output logic                cfg_ready,
  output logic [0:NUM_BITS-1] mem,
  output logic [0:NUM_BITS-1] mem_inv,
  output logic                ccff_tail,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                cfg_err
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [0:NUM_BITS-1] shadow_q, shadow_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [0:NUM_BITS-1] mem_q, mem_d;
  logic [0:NUM_BITS-1] mem_inv_q, mem_inv_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef CFG_PARITY_EN
  logic                err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    idx_d     = idx_q;
    mem_d     = mem_q;
    mem_inv_d = mem_inv_q;
`ifdef CFG_PARITY_EN
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d   = S_LOAD;
          shadow_d  = '0;
          bit_cnt_d = '0;
`ifdef CFG_PARITY_EN
          err_d     = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (cfg_valid) begin
          state_d = S_SHIFT;
          word_d  = cfg_word;
          idx_d   = '0;
`ifdef CFG_PARITY_EN
          if (^{cfg_parity, cfg_word}) err_d = 1'b1;
`endif
        end
      end
      S_SHIFT: begin
        shadow_d  = {word_q[0], shadow_q[0:NUM_BITS-2]};
        word_d    = word_q >> 1;
        idx_d     = idx_q + IDX_W'(1);
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        // Chain completion wins over word exhaustion so surplus bits of the last word are dropped.
        if (bit_cnt_q == CNT_LAST) begin
          state_d = S_COMMIT;
        end else if (idx_q == IDX_LAST) begin
          state_d = S_LOAD;
        end
      end
      S_COMMIT: begin
        state_d = S_DONE;
`ifdef CFG_PARITY_EN
        if (!err_q) begin
          mem_d     = shadow_q;
          mem_inv_d = ~shadow_q;
        end
`else
        mem_d     = shadow_q;
        mem_inv_d = ~shadow_q;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_COMMIT);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      mem_q     <= '0;
      mem_inv_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CFG_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      mem_q     <= mem_d;
      mem_inv_q <= mem_inv_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CFG_PARITY_EN
      err_q     <= err_d;
`endif
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;
  assign mem       = mem_q;
  assign mem_inv   = mem_inv_q;
  assign ccff_tail = shadow_q[NUM_BITS-1];
`ifdef CFG_PARITY_EN
  assign cfg_err   = err_q;
`else
  assign cfg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mux_cfg_mem_loader.sv
// Bench for mux_cfg_mem_loader: a 16-bit and a 12-bit chain share one stimulus stream and are checked every cycle
// against a bitstream-level model; honours CFG_PARITY_EN when defined.
module tb_mux_cfg_mem_loader;
  localparam int W = 8;
  localparam int P_IDLE = 0, P_LOAD = 1, P_SHIFT = 2, P_COMMIT = 3, P_DONE = 4;

  logic         prog_clk  = 1'b0;
  logic         pReset_n  = 1'b0;
  logic         cfg_start = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_word  = '0;
`ifdef CFG_PARITY_EN
  logic         cfg_parity = 1'b0;
`endif

  logic         rdy16, busy16, done16, err16, tail16;
  logic [0:15]  mem16, inv16;
  logic         rdy12, busy12, done12, err12, tail12;
  logic [0:11]  mem12, inv12;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 prog_clk = ~prog_clk;

  mux_cfg_mem_loader #(.NUM_BITS(16), .WORD_W(W)) u_dut16 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .cfg_start(cfg_start),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid),
`ifdef CFG_PARITY_EN
    .cfg_parity(cfg_parity),
`endif
    .cfg_ready(rdy16), .mem(mem16), .mem_inv(inv16), .ccff_tail(tail16),
    .cfg_busy(busy16), .cfg_done(done16), .cfg_err(err16)
  );

  mux_cfg_mem_loader #(.NUM_BITS(12), .WORD_W(W)) u_dut12 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .cfg_start(cfg_start),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid),
`ifdef CFG_PARITY_EN
    .cfg_parity(cfg_parity),
`endif
    .cfg_ready(rdy12), .mem(mem12), .mem_inv(inv12), .ccff_tail(tail12),
    .cfg_busy(busy12), .cfg_done(done12), .cfg_err(err12)
  );

  // Model: collects the accepted bitstream; on commit mem[k] is stream bit N-1-k.
  int           ph  [2];
  int           cnt [2];
  int           idx [2];
  logic [W-1:0] wd  [2];
  logic         strm[2][16];
  logic [0:15]  emem[2];
  logic [0:15]  einv[2];
  logic         eerr[2];

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      ph[d] = P_IDLE; cnt[d] = 0; idx[d] = 0; wd[d] = '0;
      emem[d] = '0; einv[d] = '0; eerr[d] = 1'b0;
      for (int k = 0; k < 16; k++) strm[d][k] = 1'b0;
    end
  endtask

  task automatic mstep(input int d);
    int n;
    n = (d == 0) ? 16 : 12;
    case (ph[d])
      P_IDLE: if (cfg_start) begin
        ph[d] = P_LOAD; cnt[d] = 0; eerr[d] = 1'b0;
      end
      P_LOAD: if (cfg_valid) begin
        wd[d] = cfg_word; idx[d] = 0; ph[d] = P_SHIFT;
`ifdef CFG_PARITY_EN
        if (^{cfg_parity, cfg_word}) eerr[d] = 1'b1;
`endif
      end
      P_SHIFT: begin
        strm[d][cnt[d]] = wd[d][idx[d]];
        cnt[d]++; idx[d]++;
        if (cnt[d] == n) ph[d] = P_COMMIT;
        else if (idx[d] == W) ph[d] = P_LOAD;
      end
      P_COMMIT: begin
        if (!eerr[d]) begin
          for (int k = 0; k < n; k++) begin
            emem[d][k] = strm[d][n-1-k];
            einv[d][k] = ~strm[d][n-1-k];
          end
        end
        ph[d] = P_DONE;
      end
      default: ph[d] = P_IDLE;
    endcase
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : model_proc
    mreset();
    forever begin
      @(posedge prog_clk or negedge pReset_n);
      if (!pReset_n) mreset();
      else begin
        mstep(0);
        mstep(1);
      end
    end
  end

  initial begin : cmp_proc
    logic [15:0] af, ef, am, ai;
    int n;
    forever begin
      @(posedge prog_clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        n  = (d == 0) ? 16 : 12;
        af = (d == 0) ? {11'b0, rdy16, busy16, done16, err16, tail16}
                      : {11'b0, rdy12, busy12, done12, err12, tail12};
        am = (d == 0) ? mem16 : {mem12, 4'b0};
        ai = (d == 0) ? inv16 : {inv12, 4'b0};
        ef = {11'b0, ph[d] == P_LOAD, (ph[d] >= P_LOAD) && (ph[d] <= P_COMMIT),
              ph[d] == P_DONE, eerr[d], (cnt[d] == n) ? strm[d][0] : 1'b0};
        chk($sformatf("flags_n%0d", n), af, ef);
        chk($sformatf("mem_n%0d", n), am, emem[d]);
        chk($sformatf("mem_inv_n%0d", n), ai, einv[d]);
      end
    end
  end

  task automatic idle_junk(input int cycles);
    repeat (cycles) begin
      @(negedge prog_clk);
      cfg_start = 1'b0;
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_word  = W'($urandom);
    end
    @(negedge prog_clk);
    cfg_valid = 1'b0;
  endtask

  // Runs one two-word load; dcyc is the cycle (start cycle = 0) in which cfg_done is seen.
  task automatic run_load(input logic [W-1:0] w0, input logic [W-1:0] w1, input int stall_pct,
                          input int forced, input bit bad_par, output int dcyc);
    logic [W-1:0] q[2];
    int  i, fs;
    bit  hs;
    q[0] = w0; q[1] = w1; i = 0; fs = forced; dcyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge prog_clk);
      cfg_start = (k == 0) ? 1'b1 : (busy16 && busy12 && ($urandom_range(0, 9) == 0));
      if (i < 2) begin
        cfg_word = q[i];
        if (rdy16 && i == 0 && fs > 0) begin
          cfg_valid = 1'b0;
          fs--;
        end else begin
          cfg_valid = ($urandom_range(0, 99) >= stall_pct);
        end
      end else begin
        cfg_word  = W'($urandom);
        cfg_valid = 1'($urandom_range(0, 1));
      end
`ifdef CFG_PARITY_EN
      cfg_parity = (^cfg_word) ^ (bad_par && i == 0);
`endif
      hs = rdy16 && cfg_valid && (i < 2);
      @(posedge prog_clk);
      #1;
      if (hs) i++;
      if (done16) begin
        dcyc = k + 1;
        break;
      end
    end
    @(negedge prog_clk);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    if (dcyc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_timeout: got no cfg_done expected one within 200 cycles");
    end
  endtask

  initial begin : main_proc
    int dc;
    logic [0:15] saved;
    repeat (3) @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);
    chk("reset_mem", mem16, 16'h0000);
    chk("reset_flags", {11'b0, rdy16, busy16, done16, err16, tail16}, 16'h0000);

    idle_junk(3);
    run_load(8'hA5, 8'h3C, 0, 0, 1'b0, dc);
    chk("latency_a5_3c", 16'(dc), 16'd20);
    chk("lit_mem16_3ca5", mem16, 16'h3CA5);
    chk("lit_inv16_3ca5", inv16, 16'hC35A);
    chk("lit_mem12_ca5", {mem12, 4'b0}, 16'hCA50);
    chk("tail16_first_bit", {15'b0, tail16}, 16'h0001);

    idle_junk(2);
    run_load(8'h00, 8'h00, 0, 0, 1'b0, dc);
    chk("latency_zero", 16'(dc), 16'd20);
    chk("lit_mem16_zero", mem16, 16'h0000);
    chk("lit_inv16_ones", inv16, 16'hFFFF);

    idle_junk(2);
    run_load(8'hFF, 8'hF0, 0, 0, 1'b0, dc);
    chk("lit_mem12_0ff", {mem12, 4'b0}, 16'h0FF0);
    chk("lit_inv12_f00", {inv12, 4'b0}, 16'hF000);
    chk("lit_mem16_f0ff", mem16, 16'hF0FF);

    idle_junk(2);
    run_load(8'h11, 8'h22, 0, 5, 1'b0, dc);
    chk("latency_stall5", 16'(dc), 16'd25);

    // Reset in the middle of shifting.
    idle_junk(2);
    @(negedge prog_clk);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_word = W'($urandom);
`ifdef CFG_PARITY_EN
    cfg_parity = ^cfg_word;
`endif
    @(negedge prog_clk);
    cfg_start = 1'b0;
    repeat (4) @(negedge prog_clk);
    chk("busy_before_reset", {15'b0, busy16}, 16'h0001);
    pReset_n = 1'b0;
    #1;
    chk("rst_mem16", mem16, 16'h0000);
    chk("rst_inv16", inv16, 16'h0000);
    chk("rst_busy_ready", {14'b0, busy16, rdy16}, 16'h0000);
    chk("rst_mem12", {mem12, 4'b0}, 16'h0000);
    @(negedge prog_clk);
    cfg_valid = 1'b0;
    @(negedge prog_clk);
    pReset_n = 1'b1;

`ifdef CFG_PARITY_EN
    idle_junk(2);
    run_load(8'h5A, 8'hC3, 0, 0, 1'b0, dc);
    saved = mem16;
    idle_junk(2);
    run_load(8'h01, 8'h00, 0, 0, 1'b1, dc);
    chk("parity_latency", 16'(dc), 16'd20);
    chk("parity_err_set", {15'b0, err16}, 16'h0001);
    chk("parity_mem_held", mem16, saved);
    idle_junk(2);
    run_load(8'h01, 8'h80, 0, 0, 1'b0, dc);
    chk("parity_err_cleared", {15'b0, err16}, 16'h0000);
`else
    saved = '0;
`endif

    for (int r = 0; r < 12; r++) begin
      idle_junk($urandom_range(2, 4));
      run_load(W'($urandom), W'($urandom), 30, $urandom_range(0, 3), 1'b0, dc);
    end
    idle_junk(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
